// File: rtl/alu_wide_seq_pkg.sv
// Shared types for the wide ALU sequencer: ALU control codes, wide op codes, FSM states.
// Optional macro ALU_SEQ_CMP_EN enables WOP_LT (unsigned compare, run as a wide subtract).
package alu_wide_seq_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } ALU_CTRL;

    typedef enum logic [2:0] {
        WOP_ADD = 3'd0,
        WOP_SUB = 3'd1,
        WOP_AND = 3'd2,
        WOP_OR  = 3'd3,
        WOP_LT  = 3'd4
    } WIDE_OP;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_PASS1 = 2'd1,
        SEQ_PASS2 = 2'd2,
        SEQ_DONE  = 2'd3
    } SEQ_STATE;

    function automatic logic op_is_sub(WIDE_OP op);
`ifdef ALU_SEQ_CMP_EN
        return (op == WOP_SUB) || (op == WOP_LT);
`else
        return (op == WOP_SUB);
`endif
    endfunction

    function automatic logic op_is_arith(WIDE_OP op);
        return (op == WOP_ADD) || op_is_sub(op);
    endfunction

    function automatic logic op_supported(WIDE_OP op);
        return op_is_arith(op) || (op == WOP_AND) || (op == WOP_OR);
    endfunction

    function automatic ALU_CTRL op_ctrl(WIDE_OP op);
        ALU_CTRL c;
        case (op)
            WOP_AND: c = ALU_AND;
            WOP_OR:  c = ALU_OR;
            default: c = op_is_sub(op) ? ALU_SUB : ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_wide_seq_if.sv
// Request/response handshake bundle between the datapath controller and the wide ALU sequencer.
interface alu_wide_seq_if
    import alu_wide_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 4
);
    logic                  req_valid;
    logic                  req_ready;
    WIDE_OP                req_op;
    logic [8*NBYTES-1:0]   req_a;
    logic [8*NBYTES-1:0]   req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [8*NBYTES-1:0]   rsp_result;
    logic                  rsp_carry;
    logic                  rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );
endinterface

// File: rtl/alu_seq_carry.sv
// Carry-out (add) or borrow-out (subtract) of an 8-bit op, recovered from operand and result MSBs.
module alu_seq_carry (
    input  logic a7,
    input  logic b7,
    input  logic out7,
    input  logic is_sub,
    output logic carry
);
    always_comb begin
        if (is_sub) carry = (~a7 & b7) | ((~a7 | b7) & out7);
        else        carry = (a7 & b7) | ((a7 | b7) & ~out7);
    end
endmodule

// File: rtl/alu_wide_seq.sv
// Multi-cycle wide-op initiator driving one combinational 8-bit ALU, byte by byte, LSB first.
// Macro ALU_SEQ_CMP_EN adds WOP_LT; without it WOP_LT is treated as an unsupported code.
module alu_wide_seq
    import alu_wide_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_wide_seq_if.slave  bus,
    output ALU_CTRL        alu_ctrl,
    output logic [7:0]     alu_a,
    output logic [7:0]     alu_b,
    input  logic [7:0]     alu_out,
    input  logic           alu_zero
);
    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    SEQ_STATE        state, state_nx;
    WIDE_OP          op_q;
    logic [W-1:0]    a_q, b_q, r_q;
    logic [IW-1:0]   idx;
    logic [7:0]      p_q;
    logic            cin, c1_q, zacc;
    logic [7:0]      a_byte, b_byte;
    logic            c1, c2, is_sub, byte_final;

    assign a_byte = a_q[{idx, 3'b000} +: 8];
    assign b_byte = b_q[{idx, 3'b000} +: 8];
    assign is_sub = op_is_sub(op_q);

    // PASS1 carry comes from the operand bytes, PASS2 carry from p +/- 1.
    alu_seq_carry u_carry1 (
        .a7     (a_byte[7]),
        .b7     (b_byte[7]),
        .out7   (alu_out[7]),
        .is_sub (is_sub),
        .carry  (c1)
    );

    alu_seq_carry u_carry2 (
        .a7     (p_q[7]),
        .b7     (1'b0),
        .out7   (alu_out[7]),
        .is_sub (is_sub),
        .carry  (c2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEQ_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        byte_final     = 1'b0;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_result = '0;
        bus.rsp_carry  = 1'b0;
        bus.rsp_zero   = 1'b0;
        alu_ctrl       = ALU_ADD;
        alu_a          = '0;
        alu_b          = '0;
        case (state)
            SEQ_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_nx = op_supported(bus.req_op) ? SEQ_PASS1 : SEQ_DONE;
            end
            SEQ_PASS1: begin
                alu_ctrl = op_ctrl(op_q);
                alu_a    = a_byte;
                alu_b    = b_byte;
                if (op_is_arith(op_q) && cin) begin
                    state_nx = SEQ_PASS2;
                end else begin
                    byte_final = 1'b1;
                    state_nx   = (idx == LAST) ? SEQ_DONE : SEQ_PASS1;
                end
            end
            SEQ_PASS2: begin
                alu_ctrl   = is_sub ? ALU_SUB : ALU_ADD;
                alu_a      = p_q;
                alu_b      = 8'h01;
                byte_final = 1'b1;
                state_nx   = (idx == LAST) ? SEQ_DONE : SEQ_PASS1;
            end
            SEQ_DONE: begin
                bus.rsp_valid  = 1'b1;
                bus.rsp_result = r_q;
                bus.rsp_carry  = cin;
                bus.rsp_zero   = zacc;
`ifdef ALU_SEQ_CMP_EN
                if (op_q == WOP_LT) begin
                    bus.rsp_result = W'(cin);
                    bus.rsp_zero   = ~cin;
                end
`endif
                if (bus.rsp_ready) state_nx = SEQ_IDLE;
            end
            default: state_nx = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= WOP_ADD;
            a_q  <= '0;
            b_q  <= '0;
            r_q  <= '0;
            idx  <= '0;
            p_q  <= '0;
            cin  <= 1'b0;
            c1_q <= 1'b0;
            zacc <= 1'b1;
        end else begin
            if (state == SEQ_IDLE && bus.req_valid) begin
                op_q <= bus.req_op;
                a_q  <= bus.req_a;
                b_q  <= bus.req_b;
                r_q  <= '0;
                idx  <= '0;
                cin  <= 1'b0;
                zacc <= 1'b1;
            end
            if (state == SEQ_PASS1) begin
                p_q  <= alu_out;
                c1_q <= c1;
            end
            if (byte_final) begin
                r_q[{idx, 3'b000} +: 8] <= alu_out;
                zacc <= zacc & alu_zero;
                if (!op_is_arith(op_q))       cin <= 1'b0;
                else if (state == SEQ_PASS2)  cin <= c1_q | c2;
                else                          cin <= c1;
                if (idx != LAST) idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Scoreboard bench for alu_wide_seq (NBYTES=4) with a behavioural 8-bit ALU on the ALU port.
// Reference model works on whole 32-bit operands; honours ALU_SEQ_CMP_EN like the design.
module tb_alu_wide_seq;
    import alu_wide_seq_pkg::*;

    localparam int unsigned NB = 4;

    typedef struct {
        logic [31:0] result;
        logic        carry;
        logic        zero;
        int unsigned lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_wide_seq_if #(.NBYTES(NB)) bus ();

    ALU_CTRL     alu_ctrl;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic        alu_zero;

    alu_wide_seq #(.NBYTES(NB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_ctrl (alu_ctrl),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .alu_zero (alu_zero)
    );

    always_comb begin
        case (alu_ctrl)
            ALU_SUB: alu_out = alu_a - alu_b;
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_OR:  alu_out = alu_a | alu_b;
            default: alu_out = alu_a + alu_b;
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic exp_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        exp_t        e;
        logic [63:0] m, la, lb;
        int unsigned ncin = 0;
        logic        arith = 1'b0;
        logic        sub = 1'b0;
        logic        ok = 1'b1;
        e.result = '0;
        e.carry  = 1'b0;
        case (op)
            3'd0: begin {e.carry, e.result} = {1'b0, a} + {1'b0, b}; arith = 1'b1; end
            3'd1: begin e.result = a - b; e.carry = (a < b); arith = 1'b1; sub = 1'b1; end
            3'd2: e.result = a & b;
            3'd3: e.result = a | b;
`ifdef ALU_SEQ_CMP_EN
            3'd4: begin e.carry = (a < b); e.result = {31'b0, e.carry}; arith = 1'b1; sub = 1'b1; end
`endif
            default: ok = 1'b0;
        endcase
        e.zero = (e.result == 32'h0);
        // A byte costs an extra pass whenever the lower bytes carried/borrowed into it.
        if (arith) begin
            for (int unsigned i = 1; i < NB; i++) begin
                m  = 64'd1 << (8 * i);
                la = {32'b0, a} & (m - 1);
                lb = {32'b0, b} & (m - 1);
                if (sub ? (la < lb) : (la + lb >= m)) ncin++;
            end
        end
        e.lat = ok ? NB + ncin + 1 : 1;
        return e;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.req_valid && bus.req_ready) acc_cyc <= cyc;
    end

    logic        seen = 1'b0;
    logic [33:0] first_rsp;
    int unsigned lat_obs = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.rsp_valid) begin
            if (!seen) begin
                seen      = 1'b1;
                first_rsp = {bus.rsp_result, bus.rsp_carry, bus.rsp_zero};
                lat_obs   = cyc - acc_cyc;
            end else begin
                check("rsp_stable", {30'b0, bus.rsp_result, bus.rsp_carry, bus.rsp_zero}, {30'b0, first_rsp});
            end
            check("done_req_ready", 64'(bus.req_ready), 64'd0);
            check("done_alu_idle", {46'b0, alu_ctrl, alu_a, alu_b}, {46'b0, ALU_ADD, 8'h00, 8'h00});
            if (bus.rsp_ready) begin
                check("rsp_expected", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("rsp_result", 64'(bus.rsp_result), 64'(e.result));
                    check("rsp_carry", 64'(bus.rsp_carry), 64'(e.carry));
                    check("rsp_zero", 64'(bus.rsp_zero), 64'(e.zero));
                    check("rsp_latency", 64'(lat_obs), 64'(e.lat));
                end
                seen = 1'b0;
            end
        end
    end

    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned stall);
        int unsigned n = 0;
        check("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = WIDE_OP'(op);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = (stall == 0);
        sbq.push_back(model(op, a, b));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        while (!bus.rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("rsp_valid_arrives", 64'(bus.rsp_valid), 64'd1);
        if (!bus.rsp_valid) begin
            sbq.delete();
        end else begin
            repeat (stall) begin
                @(posedge clk); #1;
            end
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = WOP_ADD;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        #22;
        check("reset_state",
              {10'b0, bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, alu_ctrl, alu_a, alu_b},
              {10'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, ALU_ADD, 8'h00, 8'h00});
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(3'd0, 32'h000000FF, 32'h00000001, 0);
        do_req(3'd0, 32'hFFFFFFFF, 32'h00000001, 0);
        do_req(3'd1, 32'h00000000, 32'h00000001, 0);
        do_req(3'd1, 32'h00001234, 32'h00001234, 0);
        do_req(3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 3);
        do_req(3'd3, 32'h12345678, 32'h80000001, 1);
        do_req(3'd4, 32'd3, 32'd5, 0);
        do_req(3'd4, 32'd5, 32'd3, 0);
        do_req(3'd7, 32'hDEADBEEF, 32'h1, 0);

        // Abort an ADD in byte 1's second pass, then make sure the next request is clean.
        bus.req_valid = 1'b1;
        bus.req_op    = WOP_ADD;
        bus.req_a     = 32'h000000FF;
        bus.req_b     = 32'h00000001;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pass2_alu_drive", {46'b0, alu_ctrl, alu_a, alu_b}, {46'b0, ALU_ADD, 8'h00, 8'h01});
        rst_n = 1'b0;
        #1;
        check("reset_mid_op",
              {10'b0, bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, alu_ctrl, alu_a, alu_b},
              {10'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, ALU_ADD, 8'h00, 8'h00});
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(3'd0, 32'h0000FFFF, 32'h00010001, 0);

        for (int k = 0; k < 200; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: rb = 32'h0 - ra;
                2: begin ra = 32'hFFFFFFFF; rb = $urandom_range(0, 3); end
                default: rb = $urandom;
            endcase
            do_req(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3));
        end

        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
